// File: rtl/ez_fetch_unit_if.sv
// Fetch unit bus bundle: pause/redirect control, host load port and the fetched stream.
// Call/return signals exist only when EZ_FETCH_CALL_STACK_EN is defined.
interface ez_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned INSTR_WIDTH = 16
) ();
  logic                   pause;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_addr;
  logic [ADDR_WIDTH-1:0]  instr_writeaddr;
  logic [INSTR_WIDTH-1:0] instr_writedata;
  logic                   instr_write_en;
  logic [ADDR_WIDTH-1:0]  pc_out;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_valid;
  logic                   squash_out;
`ifdef EZ_FETCH_CALL_STACK_EN
  logic                   call_en;
  logic                   ret_en;
  logic                   stack_err;
`endif

  // Requester side (core control / host loader).
  modport master (
    output pause, redirect_valid, redirect_addr,
    output instr_writeaddr, instr_writedata, instr_write_en,
`ifdef EZ_FETCH_CALL_STACK_EN
    output call_en, ret_en,
    input  stack_err,
`endif
    input  pc_out, instr_out, instr_pc, instr_valid, squash_out
  );

  // Fetch unit side.
  modport slave (
    input  pause, redirect_valid, redirect_addr,
    input  instr_writeaddr, instr_writedata, instr_write_en,
`ifdef EZ_FETCH_CALL_STACK_EN
    input  call_en, ret_en,
    output stack_err,
`endif
    output pc_out, instr_out, instr_pc, instr_valid, squash_out
  );
endinterface

// File: rtl/ez_fetch_unit.sv
// ez8 instruction-fetch front end: PC, instruction RAM with host load port, pause,
// branch redirect and a multi-cycle squash counter for downstream write enables.
// Optional hardware call/return stack enabled by defining EZ_FETCH_CALL_STACK_EN.
// KILL_DEPTH must lie in 1..4.
module ez_fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned KILL_DEPTH  = 2,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  ez_fetch_unit_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned KillW = 2;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam addr_t            ResetPc  = addr_t'(RESET_PC);
  localparam logic [KillW-1:0] KillLoad = KillW'(KILL_DEPTH - 1);

  instr_t           mem_q [Depth];
  addr_t            pc_q, pc_d;
  addr_t            ipc_q, ipc_d;
  instr_t           instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [KillW-1:0] kill_q, kill_d;

  logic  redir_take;
  addr_t redir_target;

  // Host load port; read-before-write falls out of the nonblocking update.
  always_ff @(posedge clk) begin
    if (bus.instr_write_en) begin
      mem_q[bus.instr_writeaddr] <= bus.instr_writedata;
    end
  end

`ifdef EZ_FETCH_CALL_STACK_EN
  localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SCntW = $clog2(STACK_DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;

  localparam ptr_t             PtrLast  = ptr_t'(STACK_DEPTH - 1);
  localparam logic [SCntW-1:0] SCntFull = SCntW'(STACK_DEPTH);

  addr_t            stk_q [STACK_DEPTH];
  ptr_t             top_q, top_d, push_idx_next, pop_idx;
  logic [SCntW-1:0] cnt_q, cnt_d;
  logic             push;
  addr_t            push_addr;
  logic             err_q, err_d;

  // top_q is the next write slot; when full it also points at the oldest entry.
  always_comb begin
    pop_idx       = (top_q == '0) ? PtrLast : top_q - ptr_t'(1);
    push_idx_next = (top_q == PtrLast) ? '0 : top_q + ptr_t'(1);
  end

  // Stack control: ret beats call, and both are inert while paused.
  always_comb begin
    top_d        = top_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    push         = 1'b0;
    push_addr    = ipc_q + addr_t'(1);
    redir_take   = bus.redirect_valid;
    redir_target = bus.redirect_addr;
    if (!bus.pause) begin
      if (bus.ret_en) begin
        redir_take = 1'b1;
        if (cnt_q == '0) begin
          redir_target = ResetPc;
          err_d        = 1'b1;
        end else begin
          redir_target = stk_q[pop_idx];
          top_d        = pop_idx;
          cnt_d        = cnt_q - SCntW'(1);
        end
      end else if (bus.call_en && bus.redirect_valid) begin
        push  = 1'b1;
        top_d = push_idx_next;
        if (cnt_q == SCntFull) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + SCntW'(1);
        end
      end
    end
  end

  // Stack storage needs no reset: the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_q[top_q] <= push_addr;
    end
  end

  // Stack pointer, occupancy and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.stack_err = err_q;
`else
  assign redir_take   = bus.redirect_valid;
  assign redir_target = bus.redirect_addr;

  logic unused_stack_depth;
  assign unused_stack_depth = (STACK_DEPTH != 0);
`endif

  // Fetch next-state: pause freezes everything, redirect drops the in-flight fetch.
  always_comb begin
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    if (!bus.pause) begin
      if (redir_take) begin
        pc_d    = redir_target;
        valid_d = 1'b0;
        kill_d  = KillLoad;
      end else begin
        instr_d = mem_q[pc_q];
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + addr_t'(1);
        if (kill_q != '0) begin
          kill_d = kill_q - KillW'(1);
        end
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= ResetPc;
      ipc_q   <= ResetPc;
      instr_q <= '0;
      valid_q <= 1'b0;
      kill_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.squash_out  = (kill_q != '0);

endmodule
